// File: rtl/cnna_mac_pipe.sv
// Pipelined multiply-accumulate unit with grouped accumulation (first/last markers),
// signed/unsigned operands, per-group overflow flag and a valid/ready handshake on both sides.
module cnna_mac_pipe #(
  parameter int unsigned A_WIDTH     = 13,
  parameter int unsigned B_WIDTH     = 9,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned NUM_STAGE   = 3,
  parameter int unsigned SIGNED_MODE = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf
);

  localparam int unsigned PW = A_WIDTH + B_WIDTH;
  localparam int unsigned NS = NUM_STAGE;

  logic                 stall_c;

  logic                 op_valid_q, op_valid_d;
  logic                 op_first_q, op_first_d;
  logic                 op_last_q,  op_last_d;
  logic [A_WIDTH-1:0]   op_a_q,     op_a_d;
  logic [B_WIDTH-1:0]   op_b_q,     op_b_d;

  logic [NS-1:0]        pr_valid_q, pr_valid_d;
  logic [NS-1:0]        pr_first_q, pr_first_d;
  logic [NS-1:0]        pr_last_q,  pr_last_d;
  logic [PW-1:0]        pr_data_q [NS];
  logic [PW-1:0]        pr_data_d [NS];

  logic [ACC_WIDTH-1:0] acc_q,      acc_d;
  logic                 grp_ovf_q,  grp_ovf_d;

  logic                 res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0] res_data_q,  res_data_d;
  logic                 res_ovf_q,   res_ovf_d;

  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q,  out_data_d;
  logic                 out_ovf_q,   out_ovf_d;

  logic [PW-1:0]        a_ext_c, b_ext_c;
  logic [ACC_WIDTH-1:0] p_ext_c, base_c;
  logic [ACC_WIDTH:0]   sum_c;
  logic                 add_ovf_c, grp_c;

  // A full, unaccepted result freezes the entire pipeline.
  assign stall_c   = out_valid_q && !out_ready;
  assign in_ready  = ap_rst_n && !stall_c;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Operand extension to product width, and product extension to accumulator width.
  always_comb begin
    a_ext_c = PW'(op_a_q);
    b_ext_c = PW'(op_b_q);
    if (SIGNED_MODE != 0 && op_a_q[A_WIDTH-1]) a_ext_c = a_ext_c | ~PW'({A_WIDTH{1'b1}});
    if (SIGNED_MODE != 0 && op_b_q[B_WIDTH-1]) b_ext_c = b_ext_c | ~PW'({B_WIDTH{1'b1}});

    p_ext_c = ACC_WIDTH'(pr_data_q[NS-1]);
    if (SIGNED_MODE != 0 && pr_data_q[NS-1][PW-1]) p_ext_c = p_ext_c | ~ACC_WIDTH'({PW{1'b1}});

    base_c = pr_first_q[NS-1] ? '0 : acc_q;
    sum_c  = {1'b0, base_c} + {1'b0, p_ext_c};
    if (SIGNED_MODE != 0) begin
      add_ovf_c = (base_c[ACC_WIDTH-1] == p_ext_c[ACC_WIDTH-1]) &&
                  (sum_c[ACC_WIDTH-1] != base_c[ACC_WIDTH-1]);
    end else begin
      add_ovf_c = sum_c[ACC_WIDTH];
    end
    grp_c = (pr_first_q[NS-1] ? 1'b0 : grp_ovf_q) | add_ovf_c;
  end

  // Next-state for every stage; all registers hold while stalled.
  always_comb begin
    op_valid_d  = op_valid_q;
    op_first_d  = op_first_q;
    op_last_d   = op_last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    pr_valid_d  = pr_valid_q;
    pr_first_d  = pr_first_q;
    pr_last_d   = pr_last_q;
    pr_data_d   = pr_data_q;
    acc_d       = acc_q;
    grp_ovf_d   = grp_ovf_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (!stall_c) begin
      op_valid_d = in_valid;
      op_first_d = in_first;
      op_last_d  = in_last;
      op_a_d     = in_a;
      op_b_d     = in_b;

      pr_valid_d[0] = op_valid_q;
      pr_first_d[0] = op_first_q;
      pr_last_d[0]  = op_last_q;
      pr_data_d[0]  = a_ext_c * b_ext_c;
      for (int i = 1; i < int'(NS); i++) begin
        pr_valid_d[i] = pr_valid_q[i-1];
        pr_first_d[i] = pr_first_q[i-1];
        pr_last_d[i]  = pr_last_q[i-1];
        pr_data_d[i]  = pr_data_q[i-1];
      end

      res_valid_d = 1'b0;
      if (pr_valid_q[NS-1]) begin
        if (pr_last_q[NS-1]) begin
          acc_d       = '0;
          grp_ovf_d   = 1'b0;
          res_valid_d = 1'b1;
          res_data_d  = sum_c[ACC_WIDTH-1:0];
          res_ovf_d   = grp_c;
        end else begin
          acc_d     = sum_c[ACC_WIDTH-1:0];
          grp_ovf_d = grp_c;
        end
      end

      // Not stalled means the output slot is empty or draining this edge.
      out_valid_d = res_valid_q;
      if (res_valid_q) begin
        out_data_d = res_data_q;
        out_ovf_d  = res_ovf_q;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      op_valid_q  <= 1'b0;
      op_first_q  <= 1'b0;
      op_last_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      pr_valid_q  <= '0;
      pr_first_q  <= '0;
      pr_last_q   <= '0;
      for (int i = 0; i < int'(NS); i++) pr_data_q[i] <= '0;
      acc_q       <= '0;
      grp_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      op_valid_q  <= op_valid_d;
      op_first_q  <= op_first_d;
      op_last_q   <= op_last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      pr_valid_q  <= pr_valid_d;
      pr_first_q  <= pr_first_d;
      pr_last_q   <= pr_last_d;
      pr_data_q   <= pr_data_d;
      acc_q       <= acc_d;
      grp_ovf_q   <= grp_ovf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_cnna_mac_pipe.sv
// Bench for cnna_mac_pipe: three instances (unsigned/32, signed/32, unsigned/22) share stimulus;
// table vectors, hand sequences for latency/backpressure/reset, and random beats vs. an arithmetic model.
module tb_cnna_mac_pipe;

  logic        ap_clk    = 1'b0;
  logic        ap_rst_n  = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_first  = 1'b0;
  logic        in_last   = 1'b0;
  logic [12:0] in_a      = '0;
  logic [8:0]  in_b      = '0;
  logic        out_ready = 1'b1;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [31:0] od0, od1;
  logic [21:0] od2;
  logic        of0, of1, of2;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int last_wait = 0;

  typedef struct { longint d0, d1, d2; bit o0, o1, o2; } exp_t;
  typedef struct {
    logic [12:0] a; logic [8:0] b; bit first, last;
    longint d0, d1, d2; bit o0, o1, o2;
  } vec_t;

  exp_t   expq[$];
  vec_t   tbl[14];
  longint acc[3];
  bit     gov[3];
  int     cw[3] = '{32, 32, 22};
  bit     cs[3] = '{1'b0, 1'b1, 1'b0};

  always #5 ap_clk = ~ap_clk;

  cnna_mac_pipe u0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ovf(of0));

  cnna_mac_pipe #(.SIGNED_MODE(1)) u1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ovf(of1));

  cnna_mac_pipe #(.ACC_WIDTH(22)) u2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_ovf(of2));

  task automatic chk(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Downstream ready generator.
  always @(posedge ap_clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = (($urandom % 10) < 7);
    endcase
  end

  // Group-level reference: true integer sums, wrapped to the accumulator width.
  task automatic model_accept(input int a, input int b, input bit f, input bit l,
                              input bit use_tbl, input exp_t tex);
    longint p, base, s, mask;
    longint res[3];
    bit     rov[3];
    bit     ov;
    exp_t   e;
    for (int c = 0; c < 3; c++) begin
      mask = (longint'(1) <<< cw[c]) - 1;
      base = f ? 0 : acc[c];
      if (cs[c]) begin
        p = longint'(a >= 4096 ? a - 8192 : a) * longint'(b >= 256 ? b - 512 : b);
        if (base > (mask >>> 1)) base = base - (mask + 1);
        s  = base + p;
        ov = (s > (mask >>> 1)) || (s < -((mask >>> 1) + 1));
      end else begin
        p  = longint'(a) * longint'(b);
        s  = base + p;
        ov = (s > mask);
      end
      s = s & mask;
      rov[c] = (f ? 1'b0 : gov[c]) | ov;
      res[c] = s;
      if (l) begin acc[c] = 0; gov[c] = 1'b0; end
      else   begin acc[c] = s; gov[c] = rov[c]; end
    end
    if (l) begin
      if (use_tbl) e = tex;
      else e = '{res[0], res[1], res[2], rov[0], rov[1], rov[2]};
      expq.push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin acc[c] = 0; gov[c] = 1'b0; end
  endtask

  // Present one beat and hold it until accepted (called at posedge+1, returns at posedge+1).
  task automatic send_beat(input logic [12:0] a, input logic [8:0] b, input bit f, input bit l,
                           input bit use_tbl, input exp_t tex);
    bit took;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l;
    took = 1'b0; n = 0;
    while (!took && n < 200) begin
      @(negedge ap_clk);
      took = rdy0;
      @(posedge ap_clk);
      n++;
    end
    last_wait = n;
    if (!took) chk("accept_timeout", 0, 1);
    else model_accept(int'(a), int'(b), f, l, use_tbl, tex);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(negedge ap_clk);
      n++;
    end
    chk("drain_pending", expq.size(), 0);
    idle(4);
  endtask

  // Output monitor: every valid cycle is checked against the head expectation.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && ov0) begin
      if (expq.size() == 0) begin
        chk("spurious_out_valid", ov0, 0);
      end else begin
        e = expq[0];
        chk("u0_data", od0, e.d0);
        chk("u0_ovf",  of0, e.o0);
        chk("u1_valid", ov1, 1);
        chk("u1_data", od1, e.d1);
        chk("u1_ovf",  of1, e.o1);
        chk("u2_valid", ov2, 1);
        chk("u2_data", od2, e.d2);
        chk("u2_ovf",  of2, e.o2);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t nul;
    exp_t tex;
    int   lat;
    bit   seen;
    logic [12:0] ra;
    logic [8:0]  rb;
    nul = '{0, 0, 0, 1'b0, 1'b0, 1'b0};

    //         a         b        f  l  d0            d1            d2       o0 o1 o2
    tbl[0]  = '{13'd8191, 9'd511, 1, 1, 64'd4185601,  64'd1,        64'd4185601, 0, 0, 0};
    tbl[1]  = '{13'd2,    9'd3,   1, 0, 64'd0,        64'd0,        64'd0,       0, 0, 0};
    tbl[2]  = '{13'd4,    9'd5,   0, 0, 64'd0,        64'd0,        64'd0,       0, 0, 0};
    tbl[3]  = '{13'd10,   9'd10,  0, 1, 64'd126,      64'd126,      64'd126,     0, 0, 0};
    tbl[4]  = '{13'd1,    9'd1,   0, 1, 64'd1,        64'd1,        64'd1,       0, 0, 0};
    tbl[5]  = '{13'd8191, 9'd511, 1, 0, 64'd0,        64'd0,        64'd0,       0, 0, 0};
    tbl[6]  = '{13'd8191, 9'd511, 0, 1, 64'd8371202,  64'd2,        64'd4176898, 0, 0, 1};
    tbl[7]  = '{13'd1,    9'd1,   1, 1, 64'd1,        64'd1,        64'd1,       0, 0, 0};
    tbl[8]  = '{13'd4096, 9'd255, 1, 1, 64'd1044480,  64'd4293922816, 64'd1044480, 0, 0, 0};
    tbl[9]  = '{13'd7,    9'd9,   1, 0, 64'd0,        64'd0,        64'd0,       0, 0, 0};
    tbl[10] = '{13'd3,    9'd3,   0, 1, 64'd72,       64'd72,       64'd72,      0, 0, 0};
    tbl[11] = '{13'd8191, 9'd511, 1, 0, 64'd0,        64'd0,        64'd0,       0, 0, 0};
    tbl[12] = '{13'd8191, 9'd511, 0, 0, 64'd0,        64'd0,        64'd0,       0, 0, 0};
    tbl[13] = '{13'd5,    9'd5,   1, 1, 64'd25,       64'd25,       64'd25,      0, 0, 0};

    model_reset();

    // Reset state.
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_data",  od0, 0);
    chk("rst_out_ovf",   of0, 0);
    chk("rst_in_ready",  rdy0, 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_in_ready", rdy0, 1);
    @(posedge ap_clk);
    #1;

    // Table vectors, back-to-back with the output always ready.
    for (int i = 0; i < 14; i++) begin
      tex = '{tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].o0, tbl[i].o1, tbl[i].o2};
      send_beat(tbl[i].a, tbl[i].b, tbl[i].first, tbl[i].last, 1'b1, tex);
      chk("throughput_wait", last_wait, 1);
    end
    wait_drain();

    // Latency of a single-beat group.
    send_beat(13'd8191, 9'd511, 1'b1, 1'b1, 1'b0, nul);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge ap_clk);
      if (ov0 && lat < 0) lat = n;
    end
    chk("latency", lat, 5);
    wait_drain();

    // Backpressure with two groups in flight.
    rdy_mode = 0;
    idle(2);
    send_beat(13'd2,  9'd3,  1'b1, 1'b0, 1'b0, nul);
    send_beat(13'd4,  9'd5,  1'b0, 1'b0, 1'b0, nul);
    send_beat(13'd10, 9'd10, 1'b0, 1'b1, 1'b0, nul);
    send_beat(13'd1,  9'd1,  1'b0, 1'b1, 1'b0, nul);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge ap_clk);
      seen = ov0;
    end
    chk("bp_out_valid", ov0, 1);
    chk("bp_in_ready_low", rdy0, 0);
    repeat (4) begin
      @(negedge ap_clk);
      chk("bp_hold_in_ready", rdy0, 0);
      chk("bp_hold_data", od0, 126);
    end
    @(posedge ap_clk);
    #1 rdy_mode = 1;
    wait_drain();

    // Reset in the middle of a group, then a clean single beat.
    send_beat(13'd5, 9'd5, 1'b1, 1'b0, 1'b0, nul);
    send_beat(13'd6, 9'd6, 1'b0, 1'b0, 1'b0, nul);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("midrst_in_ready", rdy0, 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    model_reset();
    @(negedge ap_clk);
    chk("midrst_out_valid", ov0, 0);
    chk("midrst_out_data",  od0, 0);
    chk("midrst_out_ovf",   of0, 0);
    chk("midrst_in_ready_after", rdy0, 1);
    @(posedge ap_clk);
    #1;
    send_beat(13'd3, 9'd3, 1'b1, 1'b1, 1'b0, nul);
    wait_drain();

    // Reset mid-group, then a last beat without first: accumulator must start from 0.
    send_beat(13'd100, 9'd100, 1'b1, 1'b0, 1'b0, nul);
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    model_reset();
    send_beat(13'd2, 9'd2, 1'b0, 1'b1, 1'b0, nul);
    wait_drain();

    // Random beats with random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 6) == 0) idle(1 + int'($urandom % 3));
      ra = 13'($urandom);
      rb = 9'($urandom);
      if (($urandom % 8) == 0) ra = (($urandom % 2) == 0) ? 13'h1FFF : 13'h1000;
      if (($urandom % 8) == 0) rb = (($urandom % 2) == 0) ? 9'h1FF : 9'h100;
      send_beat(ra, rb, (($urandom % 4) == 0), (($urandom % 4) == 0), 1'b0, nul);
    end
    send_beat(13'd1, 9'd1, 1'b0, 1'b1, 1'b0, nul);
    @(posedge ap_clk);
    #1 rdy_mode = 1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnna_mac_pipe.md
Name: cnna_mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate unit. It is the successor to the fixed-width, single-cycle unsigned multiplier cores used in the CNN datapath. It adds configurable operand and accumulator widths, configurable pipeline depth, and a signed/unsigned mode. It also adds valid/ready handshakes with backpressure and grouped accumulation using first/last markers. It sits between the feature/weight fetch stream and the partial-sum writeback logic.

Parameters:
A_WIDTH, 13, operand A width (bits)
B_WIDTH, 9, operand B width (bits)
ACC_WIDTH, 32, accumulator/result width; must be >= A_WIDTH+B_WIDTH
NUM_STAGE, 3, multiplier pipeline register stages (>=1)
SIGNED_MODE, 0, 0 = unsigned operands, 1 = two's-complement operands

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_a  in  A_WIDTH  operand A
in_b  in  B_WIDTH  operand B
in_first  in  1  beat starts a new group; accumulator treated as 0 before adding
in_last  in  1  beat ends the group; result emitted
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_WIDTH  accumulated result
out_ovf  out  1  some addition in this group overflowed ACC_WIDTH

Behaviour:
- Reset (ap_rst_n=0 at an edge): all stage valid bits 0, accumulator 0, group overflow flag 0, out_valid 0, out_data 0, out_ovf 0. in_ready is 0 while ap_rst_n is low and 1 on the first cycle after release.
- Reset mid-operation discards all in-flight beats and any partial group; no output is produced for them.
- Product: P = in_a*in_b, full width A_WIDTH+B_WIDTH. The operands are interpreted per SIGNED_MODE. P is zero-extended (mode 0) or sign-extended (mode 1) to ACC_WIDTH.
- Pipeline: operand/flag register, then NUM_STAGE product stages, then the accumulate stage. Each stage carries valid, first and last.
- Global stall: stall = out_valid && !out_ready. in_ready = !stall (registered-free, combinational). While stall is asserted, every stage and the accumulator hold.
- Bubbles (stage valid = 0) do not modify the accumulator.
- Accumulate on a valid beat: base = first ? 0 : acc. sum = base + P_ext, taken modulo 2^ACC_WIDTH.
  - Mode 0 overflow = carry out.
  - Mode 1 overflow = operands have the same sign and the sum has a different sign.
  - ovf_grp = (first ? 0 : ovf_grp) | overflow.
- On a valid last beat: out_data <= sum, out_ovf <= ovf_grp including this beat, out_valid <= 1. Accumulator and ovf_grp clear to 0, so the next group starts clean even without in_first.
- first and last on the same beat: result = P_ext, out_ovf = 0.
- Latency: a last beat accepted at edge k gives out_valid=1 after edge k+NUM_STAGE+2, absent stalls. Each stall cycle adds 1.
- Throughput: 1 beat/cycle when out_ready is held high.
- Output register: out_valid clears on out_valid && out_ready unless a new result is loaded at the same edge. Simultaneous drain and load: the new result replaces the old, and out_valid stays 1.
- out_data and out_ovf are stable while out_valid && !out_ready.
- Non-last beats never touch the output register.

Test Plan:
- Single-beat unsigned (defaults): a=8191, b=511, first=last=1 -> out_data=4185601, out_ovf=0, out_valid 5 cycles after acceptance.
- Three-beat group: (2,3),(4,5),(10,10), first on beat 1, last on beat 3, back-to-back -> one result 126. The next single beat (1,1) without first -> 1.
- Backpressure: out_ready=0 while two groups are in flight -> in_ready drops when first result is registered; out_data held at 126. Release -> results 126 then 1 delivered in order, none lost or duplicated.
- Signed mode (SIGNED_MODE=1): a=13'h1FFF, b=9'h1FF, first=last=1 -> out_data=1. Same stimulus with SIGNED_MODE=0 -> 4185601.
- Overflow (ACC_WIDTH=22, unsigned): two beats 8191*511 -> out_data=4176898, out_ovf=1. Following group (1,1) -> out_data=1, out_ovf=0.
- Reset mid-group: assert ap_rst_n=0 for 1 cycle after 2 non-last beats, then send (3,3) first=last=1 -> only output 9; out_valid, out_data, out_ovf read 0 during reset.
